// File: rtl/reg_file_2w2r_if.sv
// Register-file port bundle: two read ports, two write ports and the ready status.
//
// Handshake: there is no valid/ready transaction handshake on this bundle.
// Reads are purely combinational (rdN follows raN in the same cycle).
// Writes are single-cycle strobes, taken on the rising edge while weN is high.
// ready is a status level, not a per-transfer acknowledge. The master must
// treat the file as unavailable while ready is low: writes are ignored and
// reads return zero during that time.
interface reg_file_2w2r_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          ready;

    // Datapath side: presents addresses and write data, consumes read data.
    modport master (
        output ra0, ra1, we0, we1, wa0, wa1, wd0, wd1,
        input  rd0, rd1, ready
    );

    // Register-file side.
    modport slave (
        input  ra0, ra1, we0, we1, wa0, wa1, wd0, wd1,
        output rd0, rd1, ready
    );
endinterface

// File: rtl/reg_file_2w2r.sv
// Two-write, two-read register file with optional hard-wired zero register,
// same-cycle write-to-read bypass and a sequential clear engine started by
// synchronous reset. ready goes high once every entry has been cleared.
module reg_file_2w2r #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_2w2r_if.slave        io_bus,
    output logic                  o_dbg_state   // 0 = CLEAR, 1 = RUN
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_ready;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_wr0_en;
    logic            w_wr1_en;
    logic            w_run;
    logic [DW-1:0]   w_rd0;
    logic [DW-1:0]   w_rd1;

    assign w_run = (r_state == S_RUN);

    // Writes to entry 0 are dropped when it is hard-wired to zero.
    assign w_wr0_en = io_bus.we0 && !((ZERO_R0 != 0) && (io_bus.wa0 == '0));
    assign w_wr1_en = io_bus.we1 && !((ZERO_R0 != 0) && (io_bus.wa1 == '0));

    // Control FSM: walk the clear counter across every entry, then run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear one entry per cycle in CLEAR, take port writes in RUN.
    // Port 1 is written last so it wins an address conflict with port 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wr0_en) r_mem[io_bus.wa0] <= io_bus.wd0;
                if (w_wr1_en) r_mem[io_bus.wa1] <= io_bus.wd1;
            end
        end
    end

    // Combinational read mux: zero outside RUN, zero for entry 0 when hard-wired,
    // otherwise bypass (port 1 before port 0) and finally the stored value.
    always_comb begin
        w_rd0 = '0;
        w_rd1 = '0;
        if (w_run) begin
            if ((ZERO_R0 != 0) && (io_bus.ra0 == '0))
                w_rd0 = '0;
            else if ((BYPASS != 0) && io_bus.we1 && (io_bus.wa1 == io_bus.ra0))
                w_rd0 = io_bus.wd1;
            else if ((BYPASS != 0) && io_bus.we0 && (io_bus.wa0 == io_bus.ra0))
                w_rd0 = io_bus.wd0;
            else
                w_rd0 = r_mem[io_bus.ra0];

            if ((ZERO_R0 != 0) && (io_bus.ra1 == '0))
                w_rd1 = '0;
            else if ((BYPASS != 0) && io_bus.we1 && (io_bus.wa1 == io_bus.ra1))
                w_rd1 = io_bus.wd1;
            else if ((BYPASS != 0) && io_bus.we0 && (io_bus.wa0 == io_bus.ra1))
                w_rd1 = io_bus.wd0;
            else
                w_rd1 = r_mem[io_bus.ra1];
        end
    end

    assign io_bus.rd0   = w_rd0;
    assign io_bus.rd1   = w_rd1;
    assign io_bus.ready = r_ready;
    assign o_dbg_state  = r_state;

endmodule
